icache_assoc: RTL and testbench

- Parametrised, read-only, N-way set-associative instruction cache.
- Sits between the fetch stage's SRAM-like request port and the AXI read channel.
- Next generation of the two-way fixed-geometry icache:
  - configurable ways, sets and line length;
  - invalid-way-first victim selection with per-set round-robin;
  - pipelined back-to-back hits;
  - bus-error-safe refill;
  - uncached single-beat path.

---
 rtl/icache_pkg.sv | 37 +++
 rtl/icache_way.sv | 67 ++++++
 rtl/icache_assoc.sv | 260 ++++++++++++++++++++++++++
 tb/tb_icache_assoc.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared definitions for the set-associative instruction cache:
// FSM encoding, AXI read-channel constants and geometry helpers.
package icache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_AR,
        S_MISS_R,
        S_REFILL,
        S_UC_AR,
        S_UC_R,
        S_RESP
    } state_e;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_4B     = 3'b010;
    localparam logic [1:0] RESP_OKAY   = 2'b00;

    function automatic int unsigned off_w(input int unsigned line_words);
        return $clog2(line_words);
    endfunction

    function automatic int unsigned idx_w(input int unsigned sets);
        return $clog2(sets);
    endfunction

    function automatic int unsigned tag_w(input int unsigned sets, input int unsigned line_words);
        return 32 - idx_w(sets) - off_w(line_words) - 2;
    endfunction

    function automatic int unsigned way_w(input int unsigned ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: resettable valid array, tag RAM and word-addressed data RAM.
// All reads are synchronous with one cycle of latency.
module icache_way
    import icache_pkg::*;
#(
    parameter int unsigned SETS       = 128,
    parameter int unsigned LINE_WORDS = 8,
    parameter int unsigned IDX_W      = idx_w(SETS),
    parameter int unsigned OFF_W      = off_w(LINE_WORDS),
    parameter int unsigned TAG_W      = tag_w(SETS, LINE_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [OFF_W-1:0] rd_off,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_word,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             word_we,
    input  logic [OFF_W-1:0] wr_off,
    input  logic [31:0]      wr_word,
    input  logic             tag_we,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             wr_valid,
    input  logic             inv_we,
    input  logic [IDX_W-1:0] inv_idx
);

    logic [SETS-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [31:0]      data_mem [SETS][LINE_WORDS];
    logic             rd_valid_q;
    logic [TAG_W-1:0] rd_tag_q;
    logic [31:0]      rd_word_q;

    // Valid bits: written with the tag at refill, cleared by invalidate
    always_comb begin
        valid_d = valid_q;
        if (inv_we) valid_d[inv_idx] = 1'b0;
        if (tag_we) valid_d[wr_idx]  = wr_valid;
    end

    // Valid array and its registered read port
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            rd_valid_q <= valid_q[rd_idx];
        end
    end

    // Tag and data RAMs: independent write enables, registered read
    always_ff @(posedge clk) begin
        if (tag_we)  tag_mem[wr_idx]          <= wr_tag;
        if (word_we) data_mem[wr_idx][wr_off] <= wr_word;
        rd_tag_q  <= tag_mem[rd_idx];
        rd_word_q <= data_mem[rd_idx][rd_off];
    end

    assign rd_valid = rd_valid_q;
    assign rd_tag   = rd_tag_q;
    assign rd_word  = rd_word_q;

endmodule

// File: rtl/icache_assoc.sv
// Read-only N-way set-associative instruction cache between the fetch
// SRAM-like port and the AXI read channel. Optional set invalidation
// port is enabled with `define ICACHE_INVALIDATE_EN.
module icache_assoc
    import icache_pkg::*;
#(
    parameter int unsigned WAYS       = 2,
    parameter int unsigned SETS       = 128,
    parameter int unsigned LINE_WORDS = 8,
    parameter int unsigned AXI_ID     = 0
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef ICACHE_INVALIDATE_EN
    input  logic                   inv_req,
    input  logic [idx_w(SETS)-1:0] inv_index,
`endif
    input  logic                   inst_req,
    input  logic [31:0]            inst_addr,
    input  logic                   inst_cache,
    output logic                   inst_addr_ok,
    output logic                   inst_data_ok,
    output logic [31:0]            inst_rdata,
    output logic [3:0]             arid,
    output logic [31:0]            araddr,
    output logic [7:0]             arlen,
    output logic [2:0]             arsize,
    output logic [1:0]             arburst,
    output logic                   arvalid,
    input  logic                   arready,
    input  logic [31:0]            rdata,
    input  logic [1:0]             rresp,
    input  logic                   rlast,
    input  logic                   rvalid,
    output logic                   rready
);

    localparam int unsigned OFF_W = off_w(LINE_WORDS);
    localparam int unsigned IDX_W = idx_w(SETS);
    localparam int unsigned TAG_W = tag_w(SETS, LINE_WORDS);
    localparam int unsigned WAY_W = way_w(WAYS);
    localparam logic [OFF_W:0] BEATS_FULL = LINE_WORDS[OFF_W:0];
    localparam logic [7:0]     LEN_LINE   = 8'(LINE_WORDS - 1);

    state_e           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic             cache_q, cache_d;
    logic [OFF_W:0]   beat_q, beat_d;
    logic             err_q, err_d;
    logic [31:0]      resp_q, resp_d;
    logic [WAY_W-1:0] victim_q, victim_d;
    logic             use_rr_q, use_rr_d;
    logic [WAY_W-1:0] rr_q [SETS];
    logic [WAY_W-1:0] rr_d [SETS];

    logic             accept, hit, inv_go, victim_rr, refill_ok;
    logic [IDX_W-1:0] inv_idx, rd_idx, cur_idx;
    logic [OFF_W-1:0] rd_off, cur_off;
    logic [TAG_W-1:0] cur_tag;
    logic [WAY_W-1:0] victim_sel;
    logic [WAYS-1:0]  way_valid, way_hit, way_word_we, way_tag_we;
    logic [TAG_W-1:0] way_tag  [WAYS];
    logic [31:0]      way_word [WAYS];
    logic [31:0]      hit_word;

`ifdef ICACHE_INVALIDATE_EN
    assign inv_go  = inv_req && (state_q == S_IDLE);
    assign inv_idx = inv_index;
`else
    assign inv_go  = 1'b0;
    assign inv_idx = '0;
`endif

    assign accept  = inst_req && inst_addr_ok;
    assign cur_off = addr_q[OFF_W+1:2];
    assign cur_idx = addr_q[OFF_W+2 +: IDX_W];
    assign cur_tag = addr_q[31 -: TAG_W];
    // RAMs are addressed by the incoming request so a hit can pipeline.
    assign rd_off  = accept ? inst_addr[OFF_W+1:2] : cur_off;
    assign rd_idx  = accept ? inst_addr[OFF_W+2 +: IDX_W] : cur_idx;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_way #(
            .SETS       (SETS),
            .LINE_WORDS (LINE_WORDS)
        ) u_way (
            .clk      (clk),
            .rst      (rst),
            .rd_idx   (rd_idx),
            .rd_off   (rd_off),
            .rd_valid (way_valid[w]),
            .rd_tag   (way_tag[w]),
            .rd_word  (way_word[w]),
            .wr_idx   (cur_idx),
            .word_we  (way_word_we[w]),
            .wr_off   (beat_q[OFF_W-1:0]),
            .wr_word  (rdata),
            .tag_we   (way_tag_we[w]),
            .wr_tag   (cur_tag),
            .wr_valid (refill_ok),
            .inv_we   (inv_go),
            .inv_idx  (inv_idx)
        );
    end

    // Tag compare across ways and selection of the hitting word
    always_comb begin
        way_hit  = '0;
        hit_word = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            way_hit[w] = way_valid[w] && (way_tag[w] == cur_tag);
            if (way_hit[w]) hit_word = hit_word | way_word[w];
        end
        hit = |way_hit;
    end

    // Victim: lowest invalid way, else the set's round-robin pointer
    always_comb begin
        victim_sel = rr_q[cur_idx];
        victim_rr  = 1'b1;
        for (int unsigned w = WAYS; w > 0; w--) begin
            if (!way_valid[w-1]) begin
                victim_sel = WAY_W'(w - 1);
                victim_rr  = 1'b0;
            end
        end
    end

    // Way write enables for refill beats and the final tag/valid write
    always_comb begin
        way_word_we = '0;
        way_tag_we  = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            way_word_we[w] = (state_q == S_MISS_R) && rvalid && (beat_q != BEATS_FULL)
                             && (victim_q == WAY_W'(w));
            way_tag_we[w]  = (state_q == S_REFILL) && (victim_q == WAY_W'(w));
        end
    end

    assign refill_ok = !err_q && (beat_q == BEATS_FULL);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (accept) state_d = inst_cache ? S_LOOKUP : S_UC_AR;
            S_LOOKUP: begin
                if (!hit)        state_d = S_MISS_AR;
                else if (accept) state_d = inst_cache ? S_LOOKUP : S_UC_AR;
                else             state_d = S_IDLE;
            end
            S_MISS_AR: if (arready) state_d = S_MISS_R;
            S_MISS_R:  if (rvalid && rlast) state_d = S_REFILL;
            S_REFILL:  state_d = S_RESP;
            S_UC_AR:   if (arready) state_d = S_UC_R;
            S_UC_R:    if (rvalid) state_d = S_RESP;
            S_RESP: begin
                if (accept) state_d = inst_cache ? S_LOOKUP : S_UC_AR;
                else        state_d = S_IDLE;
            end
            default:   state_d = S_IDLE;
        endcase
    end

    // FSM outputs on the fetch port and AR valid
    always_comb begin
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = '0;
        arvalid      = 1'b0;
        case (state_q)
            S_IDLE:   inst_addr_ok = !inv_go;
            S_LOOKUP: begin
                inst_addr_ok = hit;
                inst_data_ok = hit;
                inst_rdata   = hit_word;
            end
            S_RESP: begin
                inst_addr_ok = 1'b1;
                inst_data_ok = 1'b1;
                inst_rdata   = resp_q;
            end
            S_MISS_AR, S_UC_AR: arvalid = 1'b1;
            default: ;
        endcase
    end

    assign arid    = 4'(AXI_ID);
    assign araddr  = cache_q ? {addr_q[31:OFF_W+2], {(OFF_W+2){1'b0}}} : addr_q;
    assign arlen   = cache_q ? LEN_LINE : '0;
    assign arburst = cache_q ? BURST_INCR : BURST_FIXED;
    assign arsize  = SIZE_4B;
    assign rready  = 1'b1;

    // Datapath: request latch, refill beat tracking, response word, round-robin
    always_comb begin
        addr_d   = addr_q;
        cache_d  = cache_q;
        beat_d   = beat_q;
        err_d    = err_q;
        resp_d   = resp_q;
        victim_d = victim_q;
        use_rr_d = use_rr_q;
        rr_d     = rr_q;
        if (accept) begin
            addr_d  = inst_addr;
            cache_d = inst_cache;
        end
        case (state_q)
            S_LOOKUP: if (!hit) begin
                victim_d = victim_sel;
                use_rr_d = victim_rr;
            end
            S_MISS_R: if (rvalid) begin
                if (beat_q == {1'b0, cur_off}) resp_d = rdata;
                if (rresp != RESP_OKAY)        err_d  = 1'b1;
                // Saturates so an over-long burst can neither wrap nor overrun the line.
                if (beat_q != BEATS_FULL)      beat_d = beat_q + 1'b1;
            end
            S_REFILL: begin
                beat_d = '0;
                err_d  = 1'b0;
                if (use_rr_q)
                    rr_d[cur_idx] = (rr_q[cur_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[cur_idx] + 1'b1;
            end
            S_UC_R: if (rvalid) resp_d = rdata;
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            cache_q  <= 1'b0;
            beat_q   <= '0;
            err_q    <= 1'b0;
            resp_q   <= '0;
            victim_q <= '0;
            use_rr_q <= 1'b0;
            rr_q     <= '{default: '0};
        end else begin
            addr_q   <= addr_d;
            cache_q  <= cache_d;
            beat_q   <= beat_d;
            err_q    <= err_d;
            resp_q   <= resp_d;
            victim_q <= victim_d;
            use_rr_q <= use_rr_d;
            rr_q     <= rr_d;
        end
    end

endmodule

// File: tb/tb_icache_assoc.sv
// Self-checking bench for icache_assoc (WAYS=4, LINE_WORDS=8) with an AXI
// read slave model and a scoreboard of expected fetch words.
module tb_icache_assoc;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_cache, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr, rdata;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, rresp;
    logic        arvalid, arready, rlast, rvalid, rready;
`ifdef ICACHE_INVALIDATE_EN
    logic        inv_req;
    logic [6:0]  inv_index;
`endif

    always #5 clk = ~clk;

    icache_assoc #(
        .WAYS       (4),
        .SETS       (128),
        .LINE_WORDS (8),
        .AXI_ID     (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef ICACHE_INVALIDATE_EN
        .inv_req      (inv_req),
        .inv_index    (inv_index),
`endif
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_cache   (inst_cache),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .arid         (arid),
        .araddr       (araddr),
        .arlen        (arlen),
        .arsize       (arsize),
        .arburst      (arburst),
        .arvalid      (arvalid),
        .arready      (arready),
        .rdata        (rdata),
        .rresp        (rresp),
        .rlast        (rlast),
        .rvalid       (rvalid),
        .rready       (rready)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    // Scoreboard and data_ok run tracking
    logic [31:0] sb [$];
    int unsigned run_len = 0;
    int unsigned max_run = 0;

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (inst_data_ok) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (sb.size() == 0) check("data_ok_unexpected", 32'(sb.size()), 32'd1);
                else                check("rdata", inst_rdata, sb.pop_front());
            end else begin
                run_len = 0;
                check("rdata_zero", inst_rdata, 32'h0);
            end
            if (inst_req && inst_addr_ok) sb.push_back(mem_word(inst_addr));
        end
    end

    // AXI read slave: random arready, one beat per cycle, optional error beat
    int unsigned ar_count = 0;
    logic [31:0] ar_addr_last;
    logic [7:0]  ar_len_last;
    logic [1:0]  ar_burst_last;
    int unsigned err_beat = 99;

    initial begin
        int unsigned beat, len;
        logic [31:0] base;
        logic        incr, busy, pend;
        logic [31:0] pend_addr;
        busy = 1'b0; pend = 1'b0; pend_addr = '0;
        beat = 0; len = 0; base = '0; incr = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = '0;
        forever begin
            @(posedge clk); #1;
            rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = '0;
            if (busy) begin
                rvalid = 1'b1;
                rdata  = mem_word(incr ? base + 32'(4 * beat) : base);
                rresp  = (beat == err_beat) ? 2'b10 : 2'b00;
                rlast  = (beat == len);
                beat++;
                if (beat > len) busy = 1'b0;
            end
            arready = !busy && ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    check("ar_hold_valid", 32'(arvalid), 32'd1);
                    check("ar_hold_addr", araddr, pend_addr);
                end
                pend      = arvalid && !arready;
                pend_addr = araddr;
                if (arvalid && arready) begin
                    ar_count++;
                    ar_addr_last  = araddr;
                    ar_len_last   = arlen;
                    ar_burst_last = arburst;
                    base = araddr;
                    len  = 32'(arlen);
                    incr = (arburst == 2'b01);
                    beat = 0;
                    busy = 1'b1;
                end
            end
        end
    end

    // Present a request and hold it until accepted; returns cycles waited
    task automatic fetch(input logic [31:0] a, input logic c, output int unsigned waits);
        inst_req   = 1'b1;
        inst_addr  = a;
        inst_cache = c;
        waits      = 0;
        @(negedge clk);
        while (!inst_addr_ok && waits < 300) begin
            waits++;
            @(negedge clk);
        end
        if (!inst_addr_ok) check("accept_timeout", 32'(inst_addr_ok), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        inst_req = 1'b0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic one(input logic [31:0] a, input logic c, input string tag, input int unsigned exp_ar);
        int unsigned w, ar0;
        ar0 = ar_count;
        fetch(a, c, w);
        wait_idle();
        check(tag, ar_count - ar0, exp_ar);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned w0, w1, w2, ar0;
        logic [31:0] line3 [5];
        rst = 1'b1; inst_req = 1'b0; inst_addr = '0; inst_cache = 1'b0;
`ifdef ICACHE_INVALIDATE_EN
        inv_req = 1'b0; inv_index = '0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_addr_ok", 32'(inst_addr_ok), 32'd1);
        check("rst_data_ok", 32'(inst_data_ok), 32'd0);
        check("rst_arvalid", 32'(arvalid), 32'd0);
        check("arid", 32'(arid), 32'd5);
        check("arsize", 32'(arsize), 32'd2);
        check("rready", 32'(rready), 32'd1);
        @(posedge clk); #1;

        // Cold miss then refetch of the same line
        one(32'h1fc0_0004, 1'b1, "cold_ar_count", 1);
        check("cold_araddr", ar_addr_last, 32'h1fc0_0000);
        check("cold_arlen", 32'(ar_len_last), 32'd7);
        check("cold_arburst", 32'(ar_burst_last), 32'd1);
        one(32'h1fc0_0008, 1'b1, "hit_ar_count", 0);

        // Back-to-back hits with request held
        ar0 = ar_count;
        max_run = 0;
        fetch(32'h1fc0_0000, 1'b1, w0);
        fetch(32'h1fc0_0004, 1'b1, w1);
        fetch(32'h1fc0_0008, 1'b1, w2);
        wait_idle();
        check("seq_wait0", w0, 0);
        check("seq_wait1", w1, 0);
        check("seq_wait2", w2, 0);
        check("seq_data_run", max_run, 3);
        check("seq_ar_count", ar_count - ar0, 0);

        // Miss followed immediately by a request to the freshly refilled line
        ar0 = ar_count;
        fetch(32'h0030_0000, 1'b1, w0);
        fetch(32'h0030_001c, 1'b1, w1);
        wait_idle();
        check("refill_then_hit_ar", ar_count - ar0, 1);

        // Five lines on index 3: invalid-first fill, then round-robin eviction
        for (int unsigned k = 0; k < 5; k++) line3[k] = 32'h0010_0060 + 32'(k * 32'h1000);
        for (int unsigned k = 0; k < 5; k++) one(line3[k] + 32'(4 * k), 1'b1, "idx3_fill_ar", 1);
        one(line3[0] + 32'h4, 1'b1, "idx3_evicted_ar", 1);
        one(line3[2] + 32'h8, 1'b1, "idx3_way2_hit_ar", 0);
        one(line3[3] + 32'hc, 1'b1, "idx3_way3_hit_ar", 0);
        one(line3[4], 1'b1, "idx3_way0_hit_ar", 0);
        one(line3[1], 1'b1, "idx3_way1_evicted_ar", 1);

        // Uncached single-beat path
        one(32'hbfc0_0010, 1'b0, "uc_ar_count", 1);
        check("uc_araddr", ar_addr_last, 32'hbfc0_0010);
        check("uc_arlen", 32'(ar_len_last), 32'd0);
        check("uc_arburst", 32'(ar_burst_last), 32'd0);
        one(32'hbfc0_0010, 1'b0, "uc_repeat_ar", 1);

        // Error on beat 5: word still returned, line left invalid
        err_beat = 5;
        one(32'h0020_0014, 1'b1, "err_ar_count", 1);
        err_beat = 99;
        one(32'h0020_0000, 1'b1, "err_refetch_ar", 1);
        one(32'h0020_0004, 1'b1, "err_clean_hit_ar", 0);

`ifdef ICACHE_INVALIDATE_EN
        // Invalidate index 3 while a fetch is pending
        inv_req   = 1'b1;
        inv_index = 7'd3;
        inst_req  = 1'b1;
        inst_addr = line3[4];
        inst_cache = 1'b1;
        ar0 = ar_count;
        @(negedge clk);
        check("inv_addr_ok", 32'(inst_addr_ok), 32'd0);
        @(posedge clk); #1;
        inv_req = 1'b0;
        fetch(line3[4], 1'b1, w0);
        wait_idle();
        check("inv_miss_ar", ar_count - ar0, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
